leb128_encoder: RTL

//   Serialises a 32/64-bit integer into WebAssembly LEB128 (varintN signed or varuintN unsigned).

---
 rtl/leb128_encoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/leb128_encoder.sv
// WebAssembly LEB128 encoder: accepts a 32/64-bit value and streams its
// varint (SIGNED=1) or varuint (SIGNED=0) encoding one byte per cycle.
module leb128_encoder #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_i64,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [3:0]  out_len
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] v, v_nxt;
    logic [63:0] load_v, shift_v, sel_v, hi;
    logic        done;
    logic        out_valid_nxt, out_last_nxt;
    logic [7:0]  out_byte_nxt;
    logic [3:0]  out_len_nxt;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            v         <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
            out_len   <= '0;
        end else begin
            state     <= state_nxt;
            v         <= v_nxt;
            out_valid <= out_valid_nxt;
            out_byte  <= out_byte_nxt;
            out_last  <= out_last_nxt;
            out_len   <= out_len_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        v_nxt         = v;
        out_valid_nxt = out_valid;
        out_byte_nxt  = out_byte;
        out_last_nxt  = out_last;
        out_len_nxt   = out_len;

        if (in_i64)
            load_v = in_data;
        else if (SIGNED)
            load_v = {{32{in_data[31]}}, in_data[31:0]};
        else
            load_v = {32'b0, in_data[31:0]};

        if (SIGNED)
            shift_v = $signed(v) >>> 7;
        else
            shift_v = v >> 7;

        // The byte being registered is always derived from the value V will
        // hold next: the freshly loaded word in IDLE, the shifted word in EMIT.
        sel_v = (state == IDLE) ? load_v : shift_v;

        if (SIGNED) begin
            hi   = $signed(sel_v) >>> 7;
            done = ((hi == '0) && !sel_v[6]) || ((hi == '1) && sel_v[6]);
        end else begin
            hi   = sel_v >> 7;
            done = (hi == '0);
        end

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt     = EMIT;
                    v_nxt         = sel_v;
                    out_valid_nxt = 1'b1;
                    out_byte_nxt  = {~done, sel_v[6:0]};
                    out_last_nxt  = done;
                    out_len_nxt   = 4'd1;
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                    end else begin
                        v_nxt        = sel_v;
                        out_byte_nxt = {~done, sel_v[6:0]};
                        out_last_nxt = done;
                        out_len_nxt  = out_len + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
